// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks an N_IN-input combinational DUT through all 2^N_IN vectors,
// captures its truth table and compares it with i_expected. Optional: SWEEPER_STOP_ON_FAIL_EN.
module truth_table_sweeper #(
   parameter int N_IN        = 3,
   parameter int HOLD_CYCLES = 250
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_dut_out,
   input  logic [2**N_IN-1:0] i_expected,
   output logic [N_IN-1:0]    o_stim,
   output logic               o_busy,
   output logic               o_done,
   output logic [2**N_IN-1:0] o_table_q,
   output logic               o_match,
   output logic [N_IN-1:0]    o_fail_idx
);

   localparam int NV = 2**N_IN;
   localparam int CW = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [N_IN-1:0] r_stim;
   logic [CW-1:0]   r_cnt;
   logic [NV-1:0]   r_table;
   logic            r_match;
   logic [N_IN-1:0] r_fail_idx;
   logic            r_failed;

   logic            w_sample;
   logic            w_mis;
   logic            w_last;
   logic            w_end;
   logic [NV-1:0]   w_tbl_nxt;

   assign w_sample = (r_state == S_DRIVE) && (r_cnt == '0);
   assign w_mis    = (i_dut_out != i_expected[r_stim]);
   assign w_last   = &r_stim;

`ifdef SWEEPER_STOP_ON_FAIL_EN
   // Any mismatch ends the sweep, so a mismatch seen here is always the first one.
   assign w_end = w_last || w_mis;
`else
   assign w_end = w_last;
`endif

   // Table as it will look after this cycle's capture; used for the final compare.
   always_comb begin
      w_tbl_nxt         = r_table;
      w_tbl_nxt[r_stim] = i_dut_out;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_DRIVE;
         S_DRIVE: if (w_sample && w_end) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy = 1'b0;
      o_done = 1'b0;
      case (r_state)
         S_DRIVE: o_busy = 1'b1;
         S_DONE:  o_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_stim     <= '0;
         r_cnt      <= '0;
         r_table    <= '0;
         r_match    <= 1'b0;
         r_fail_idx <= '0;
         r_failed   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_stim     <= '0;
                  r_cnt      <= RELOAD;
                  r_table    <= '0;
                  r_match    <= 1'b0;
                  r_fail_idx <= '0;
                  r_failed   <= 1'b0;
               end
            end
            S_DRIVE: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CW'(1);
               end else begin
                  r_table <= w_tbl_nxt;
                  if (w_mis && !r_failed) begin
                     r_failed   <= 1'b1;
                     r_fail_idx <= r_stim;
                  end
                  if (w_end) begin
                     r_stim  <= '0;
                     r_match <= (w_tbl_nxt == i_expected);
                  end else begin
                     r_stim <= r_stim + N_IN'(1);
                     r_cnt  <= RELOAD;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_stim     = r_stim;
   assign o_table_q  = r_table;
   assign o_match    = r_match;
   assign o_fail_idx = r_fail_idx;

endmodule
